popcount_scheduler: RTL

POPCOUNT_SCHEDULER -- requirements
Module: popcount_scheduler

---
 rtl/popcount_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/popcount_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and default sizing for the popcount scheduler slice.
package popcount_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 9;
   localparam int DEFAULT_CW    = 4;
   localparam int DEFAULT_NREQ  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt
);

   int idx;

   // Scan from the farthest offset down so the nearest request overwrites the others.
   always_comb begin
      gnt = '0;
      idx = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            gnt = NREQ'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/popcount_scheduler.sv
// Round-robin scheduler feeding a bit-serial population counter.
// Optional POPCOUNT_PARITY_EN adds a registered parity output valid with done.
module popcount_scheduler
   import popcount_pkg::*;
#(
   parameter int NREQ  = DEFAULT_NREQ,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = DEFAULT_CW,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   word,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    done,
   output logic [CW-1:0]           ones_count,
   output logic [IW-1:0]           done_id
`ifdef POPCOUNT_PARITY_EN
   ,
   output logic                    parity
`endif
);

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  shift_reg;
   logic [CW-1:0]     acc;
   logic [CW-1:0]     bit_cnt;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     cur_id;
   logic [IW-1:0]     win_id;
   logic [NREQ-1:0]   arb_gnt;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arbiter (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt)
   );

   always_comb begin
      win_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            win_id = IW'(i);
         end
      end
   end

   // The grant is only offered in IDLE, and a reset edge suppresses it outright.
   always_comb begin
      state_nxt = state;
      gnt       = '0;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt       = arb_gnt;
               state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (bit_cnt == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         gnt = '0;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // The final bit is folded into the result on the COUNT->DONE edge so it is ready in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         acc        <= '0;
         bit_cnt    <= '0;
         ptr        <= '0;
         cur_id     <= '0;
         ones_count <= '0;
         done_id    <= '0;
`ifdef POPCOUNT_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (|req) begin
                  shift_reg <= word[win_id*WIDTH +: WIDTH];
                  acc       <= '0;
                  bit_cnt   <= CW'(WIDTH);
                  cur_id    <= win_id;
                  ptr       <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + IW'(1);
               end
            end
            COUNT: begin
               acc       <= acc + CW'(shift_reg[0]);
               shift_reg <= shift_reg >> 1;
               bit_cnt   <= bit_cnt - CW'(1);
               if (bit_cnt == CW'(1)) begin
                  ones_count <= acc + CW'(shift_reg[0]);
                  done_id    <= cur_id;
`ifdef POPCOUNT_PARITY_EN
                  parity     <= acc[0] ^ shift_reg[0];
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
